vga_timing_gen: RTL

Parametrised VGA raster timing generator that drives the pixel pipeline and the sync pins of the display output. It advances a horizontal/vertical beam position on a pixel-clock enable. It provides configurable sync polarity, line- and frame-start strobes, and an optional wrapping frame counter. All outputs are registered and mutually aligned, so every output in a given cycle describes the same pixel.

---
 rtl/vga_timing_gen.sv | 84 ++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator with registered, mutually aligned x/y, sync, blanking and strobes.
// Optional wrapping frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
   parameter int W_DISPLAY = 640,
   parameter int W_FRONT   = 16,
   parameter int W_SYNC    = 96,
   parameter int W_BACK    = 48,
   parameter int H_DISPLAY = 480,
   parameter int H_BOTTOM  = 10,
   parameter int H_SYNC    = 2,
   parameter int H_TOP     = 33,
   parameter bit H_POL     = 1'b0,
   parameter bit V_POL     = 1'b0,
   parameter int COORD_W   = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pix_en,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               h_sync,
   output logic               v_sync,
   output logic               display_on,
   output logic               line_start,
   output logic               frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,
   output logic [7:0]         frame_count
`endif
);
   localparam int W_TOTAL = W_DISPLAY + W_FRONT + W_SYNC + W_BACK;
   localparam int H_TOTAL = H_DISPLAY + H_BOTTOM + H_SYNC + H_TOP;
   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(W_TOTAL - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] X_VIS  = COORD_W'(W_DISPLAY);
   localparam logic [COORD_W-1:0] Y_VIS  = COORD_W'(H_DISPLAY);
   localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(W_DISPLAY + W_FRONT);
   localparam logic [COORD_W-1:0] HS_END = COORD_W'(W_DISPLAY + W_FRONT + W_SYNC - 1);
   localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(H_DISPLAY + H_BOTTOM);
   localparam logic [COORD_W-1:0] VS_END = COORD_W'(H_DISPLAY + H_BOTTOM + H_SYNC - 1);

   logic               x_wrap, y_wrap, hs_nxt, vs_nxt, de_nxt;
   logic [COORD_W-1:0] x_nxt, y_nxt;

   // next beam position and the sync/blank decode of that position, so outputs register in step with x/y
   always_comb begin
      x_wrap = x == X_LAST;
      y_wrap = y == Y_LAST;
      x_nxt  = x_wrap ? '0 : x + COORD_W'(1);
      y_nxt  = x_wrap ? (y_wrap ? '0 : y + COORD_W'(1)) : y;
      hs_nxt = x_nxt >= HS_BEG && x_nxt <= HS_END;
      vs_nxt = y_nxt >= VS_BEG && y_nxt <= VS_END;
      de_nxt = x_nxt < X_VIS && y_nxt < Y_VIS;
   end

   // beam state and aligned outputs; strobes are single-cycle and only raised by a real wrap
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         x           <= '0;
         y           <= '0;
         h_sync      <= ~H_POL;
         v_sync      <= ~V_POL;
         display_on  <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= pix_en && x_wrap;
         frame_start <= pix_en && x_wrap && y_wrap;
         if (pix_en) begin
            x          <= x_nxt;
            y          <= y_nxt;
            h_sync     <= hs_nxt ? H_POL : ~H_POL;
            v_sync     <= vs_nxt ? V_POL : ~V_POL;
            display_on <= de_nxt;
         end
      end

`ifdef VGA_TIMING_FRAME_CNT_EN
   // completed-frame counter, bumped on the same edge that raises frame_start
   always_ff @(posedge clk or posedge rst)
      if (rst) frame_count <= '0;
      else if (pix_en && x_wrap && y_wrap) frame_count <= frame_count + 8'd1;
`endif
endmodule
